// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//
// IF/ID pipeline register of the five-stage MIPS pipeline. Captures the
// fetch-stage PC and instruction word into the decode stage. It also flags
// instruction-fetch address errors (AdEL) and tracks the branch-delay-slot
// bit. It supports stall, flush and exception-entry bubbles, and keeps a
// saturating stall-cycle counter for performance debugging.
//
// Ports
//   clk        in   1   clock, all state updates on posedge
//   reset      in   1   synchronous active-high reset, highest priority
//   En         in   1   write enable; 0 = stall (hold all pipeline state)
//   clr        in   1   flush; load a bubble instead of PC_F/Instr_F
//   req        in   1   exception/interrupt entry; load handler bubble
//   BJ_D       in   1   instruction currently in ID is a branch/jump
//   PC_F       in  32   fetch-stage PC
//   Instr_F    in  32   instruction word read at PC_F
//   PC_D       out 32   decode-stage PC
//   Instr_D    out 32   decode-stage instruction (0 = nop)
//   ExcCode_D  out  5   0 = none, EXC_ADEL = fetch address error
//   BD_D       out  1   Instr_D sits in a branch delay slot
//   Valid_D    out  1   1 = real instruction, 0 = bubble
//   StallCnt   out 16   saturating count of stall cycles
// -----------------------------------------------------------------------------
module if_id_pipe_reg #(
  parameter logic [31:0] TEXT_START   = 32'h0000_3000,
  parameter logic [31:0] TEXT_END     = 32'h0000_6FFC,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL     = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic        clr,
  input  logic        req,
  input  logic        BJ_D,
  input  logic [31:0] PC_F,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D,
  output logic        Valid_D,
  output logic [15:0] StallCnt
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  exc_q,   exc_d;
  logic        bd_q,    bd_d;
  logic        vld_q,   vld_d;
  logic [15:0] scnt_q,  scnt_d;

  logic fetch_bad;

  // Unsigned range check plus word alignment of the fetch address.
  assign fetch_bad = (PC_F[1:0] != 2'b00) || (PC_F < TEXT_START) || (PC_F > TEXT_END);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state selection in strict priority: req, stall, flush, load.
  // Reset is applied in the register block so it wins over everything.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    vld_d   = vld_q;
    scnt_d  = scnt_q;
    if (req) begin
      // Exception entry beats a stall: the handler bubble must go in even
      // when the rest of the pipe is frozen.
      pc_d    = HANDLER_ADDR;
      instr_d = 32'd0;
      exc_d   = 5'd0;
      bd_d    = 1'b0;
      vld_d   = 1'b0;
    end else if (!En) begin
      // Hold everything; a concurrent clr is dropped so the stalled
      // instruction is not lost.
      scnt_d  = sat_inc16(scnt_q);
    end else if (clr) begin
      // Bubble keeps PC_F so an EPC taken from this slot is meaningful.
      pc_d    = PC_F;
      instr_d = 32'd0;
      exc_d   = 5'd0;
      bd_d    = 1'b0;
      vld_d   = 1'b0;
    end else begin
      pc_d    = PC_F;
      bd_d    = BJ_D;
      vld_d   = 1'b1;
      if (fetch_bad) begin
        instr_d = 32'd0;
        exc_d   = EXC_ADEL;
      end else begin
        instr_d = Instr_F;
        exc_d   = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= TEXT_START;
      instr_q <= 32'd0;
      exc_q   <= 5'd0;
      bd_q    <= 1'b0;
      vld_q   <= 1'b0;
      scnt_q  <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      vld_q   <= vld_d;
      scnt_q  <= scnt_d;
    end
  end

  assign PC_D      = pc_q;
  assign Instr_D   = instr_q;
  assign ExcCode_D = exc_q;
  assign BD_D      = bd_q;
  assign Valid_D   = vld_q;
  assign StallCnt  = scnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

  localparam logic [31:0] T_START = 32'h0000_3000;
  localparam logic [31:0] T_END   = 32'h0000_6FFC;
  localparam logic [31:0] H_ADDR  = 32'h0000_4180;

  logic        clk;
  logic        reset, En, clr, req, BJ_D;
  logic [31:0] PC_F, Instr_F;
  logic [31:0] PC_D, Instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D, Valid_D;
  logic [15:0] StallCnt;

  if_id_pipe_reg dut (
    .clk       (clk),
    .reset     (reset),
    .En        (En),
    .clr       (clr),
    .req       (req),
    .BJ_D      (BJ_D),
    .PC_F      (PC_F),
    .Instr_F   (Instr_F),
    .PC_D      (PC_D),
    .Instr_D   (Instr_D),
    .ExcCode_D (ExcCode_D),
    .BD_D      (BD_D),
    .Valid_D   (Valid_D),
    .StallCnt  (StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic        vld;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  // Reference model state: architectural view of the decode slot plus an
  // unbounded stall tally that is clipped when reported.
  logic [31:0] m_pc, m_instr;
  int          m_exc;
  logic        m_bd, m_vld;
  longint      m_stalls;

  function automatic bit addr_bad(input logic [31:0] a);
    longint u;
    u = longint'(a);
    return (u % 4 != 0) || (u < longint'(T_START)) || (u > longint'(T_END));
  endfunction

  task automatic step(input bit r, input bit en, input bit cl, input bit rq,
                      input bit bj, input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    reset = r; En = en; clr = cl; req = rq; BJ_D = bj; PC_F = pc; Instr_F = ins;
    if (r) begin
      m_pc = T_START; m_instr = 0; m_exc = 0; m_bd = 0; m_vld = 0; m_stalls = 0;
    end else if (rq) begin
      m_pc = H_ADDR; m_instr = 0; m_exc = 0; m_bd = 0; m_vld = 0;
    end else if (!en) begin
      m_stalls = m_stalls + 1;
    end else if (cl) begin
      m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_vld = 0;
    end else begin
      m_pc = pc; m_bd = bj; m_vld = 1;
      if (addr_bad(pc)) begin m_instr = 0; m_exc = 4; end
      else begin m_instr = ins; m_exc = 0; end
    end
    e.pc    = m_pc;
    e.instr = m_instr;
    e.exc   = 5'(m_exc);
    e.bd    = m_bd;
    e.vld   = m_vld;
    e.sc    = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    exp_q.push_back(e);
  endtask

  task automatic ld(input logic [31:0] pc, input logic [31:0] ins, input bit bj);
    step(0, 1, 0, 0, bj, pc, ins);
  endtask

  // Monitor: every cycle the DUT presents a fresh decode slot one edge after
  // stimulus; compare against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_step++;
        n_checks++;
        if (PC_D !== e.pc || Instr_D !== e.instr || ExcCode_D !== e.exc ||
            BD_D !== e.bd || Valid_D !== e.vld || StallCnt !== e.sc) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL slot#%0d got pc=%h instr=%h exc=%0d bd=%b vld=%b sc=%h exp pc=%h instr=%h exc=%0d bd=%b vld=%b sc=%h",
                     n_step, PC_D, Instr_D, ExcCode_D, BD_D, Valid_D, StallCnt,
                     e.pc, e.instr, e.exc, e.bd, e.vld, e.sc);
        end
      end
    end
  end

  function automatic logic [31:0] pick_pc();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1:    a = T_START + 32'($urandom_range(0, 4095)) * 4;
      2: begin
        case ($urandom_range(0, 4))
          0: a = T_START;
          1: a = T_END;
          2: a = T_END + 4;
          3: a = T_START - 4;
          default: a = T_START + 2;
        endcase
      end
      3:       a = T_START + 32'($urandom_range(0, 16383)); // often misaligned
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    reset = 1; En = 1; clr = 0; req = 0; BJ_D = 0; PC_F = 0; Instr_F = 0;
    m_pc = 0; m_instr = 0; m_exc = 0; m_bd = 0; m_vld = 0; m_stalls = 0;

    // Reset, then plain load.
    step(1, 1, 0, 0, 0, 32'h0, 32'h0);
    ld(32'h3000, 32'h3C01_1234, 0);
    ld(32'h3004, 32'h1000_0002, 0);
    // Delay slot marking and release.
    ld(32'h3008, 32'h2402_0001, 1);
    ld(32'h300C, 32'h2403_0002, 0);
    // Stall with clr asserted must hold, then the pending flush proceeds.
    ld(32'h3010, 32'h0043_2021, 0);
    repeat (3) step(0, 0, 1, 0, 1, 32'h3014, 32'hDEAD_BEEF);
    step(0, 1, 1, 0, 1, 32'h3014, 32'hDEAD_BEEF);
    // Fetch address errors and the legal top boundary.
    ld(32'h3002, 32'hFFFF_FFFF, 0);
    ld(32'h7000, 32'hFFFF_FFFF, 0);
    ld(32'h2FFC, 32'hFFFF_FFFF, 0);
    ld(32'h6FFC, 32'h0000_000C, 0);
    ld(32'h3000, 32'h1234_5678, 0);
    // Exception entry overrides stall and flush.
    step(0, 0, 1, 1, 1, 32'h3020, 32'hAAAA_5555);
    ld(32'h4184, 32'h0000_0000, 1);
    // Reset mid-stall.
    step(0, 0, 0, 0, 0, 32'h3030, 32'h1);
    step(1, 0, 1, 0, 0, 32'h3030, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, en, cl, rq;
      r  = ($urandom_range(0, 63) == 0);
      rq = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 5) == 0);
      step(r, en, cl, rq, 1'($urandom), pick_pc(), $urandom);
    end

    // Saturation of the stall counter, then reset clears it.
    step(1, 1, 0, 0, 0, 32'h0, 32'h0);
    ld(32'h3040, 32'h2408_0007, 1);
    for (int i = 0; i < 65540; i++) step(0, 0, 1'($urandom), 0, 1'($urandom), $urandom, $urandom);
    ld(32'h3044, 32'h2409_0008, 0);
    step(0, 0, 0, 0, 0, 32'h3048, 32'h0);
    step(1, 0, 0, 0, 0, 32'h3048, 32'h0);
    ld(32'h3048, 32'h240A_0009, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
